// File: rtl/cdc_word_scheduler.sv
// Source-domain scheduler sharing one multi-bit CDC word channel among NREQ requesters.
// Define CDC_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module cdc_word_scheduler #(
    parameter int WIDTH       = 8,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int IDW         = $clog2(NREQ)
) (
    input  logic                    clkA,
    input  logic                    rstA_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_word,
    output logic [NREQ-1:0]         req_ack,
    output logic [WIDTH-1:0]        wordA,
    output logic [IDW-1:0]          wordA_id,
    output logic                    wordA_stb,
    output logic                    busy
);

    localparam int CW = $clog2(HOLD_CYCLES);

    if (HOLD_CYCLES < 2) begin : g_hold_check
        $error("cdc_word_scheduler: HOLD_CYCLES must be at least 2");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_nreq_check
        $error("cdc_word_scheduler: NREQ must be in 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               stb_q, stb_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     base_s;
    logic               win_found_s;
    logic [IDW-1:0]     win_id_s;

`ifdef CDC_SCHED_FIXED_PRIO_EN
    assign base_s = '0;
`else
    logic [IDW-1:0]     rr_q, rr_d;
    assign base_s = rr_q;
`endif

    // Arbiter: scan downward so the candidate closest to base_s is the last to overwrite.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [IDW:0] sum_v;
            logic [IDW:0] cand_v;
            sum_v       = {1'b0, base_s} + (IDW+1)'(k);
            cand_v      = (sum_v >= (IDW+1)'(NREQ)) ? (sum_v - (IDW+1)'(NREQ)) : sum_v;
            win_found_s = win_found_s | req_valid[cand_v[IDW-1:0]];
            win_id_s    = req_valid[cand_v[IDW-1:0]] ? cand_v[IDW-1:0] : win_id_s;
        end
    end

    // Next-state and registered-output logic for the transfer sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        id_d    = id_q;
        stb_d   = 1'b0;
        ack_d   = '0;
        busy_d  = busy_q;
`ifndef CDC_SCHED_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    state_d = S_GRANT;
                    word_d  = req_word[win_id_s*WIDTH +: WIDTH];
                    id_d    = win_id_s;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                cnt_d   = CW'(HOLD_CYCLES - 1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
`ifndef CDC_SCHED_FIXED_PRIO_EN
                // Explicit wrap keeps the pointer legal when NREQ is not a power of two.
                rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : (id_q + 1'b1);
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clkA) begin
        if (!rstA_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            id_q    <= '0;
            stb_q   <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
`ifndef CDC_SCHED_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            id_q    <= id_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifndef CDC_SCHED_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign wordA     = word_q;
    assign wordA_id  = id_q;
    assign wordA_stb = stb_q;
    assign req_ack   = ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cdc_word_scheduler.sv
// Directed bench for cdc_word_scheduler (WIDTH=8, NREQ=4, HOLD_CYCLES=8) with a 3-stage
// behavioural destination synchronizer on an 85 ns clock against the 100 ns source clock.
module tb_cdc_word_scheduler;

    logic        clkA = 1'b0;
    logic        clkB = 1'b0;
    logic        rstA_n;
    logic [3:0]  req_valid;
    logic [31:0] req_word;
    logic [3:0]  req_ack;
    logic [7:0]  wordA;
    logic [1:0]  wordA_id;
    logic        wordA_stb;
    logic        busy;

    logic [31:0] tbl;
    logic [7:0]  s1, s2, s3;
    int          n_checks = 0;
    int          n_fail   = 0;

    cdc_word_scheduler #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(8)) dut (
        .clkA      (clkA),
        .rstA_n    (rstA_n),
        .req_valid (req_valid),
        .req_word  (req_word),
        .req_ack   (req_ack),
        .wordA     (wordA),
        .wordA_id  (wordA_id),
        .wordA_stb (wordA_stb),
        .busy      (busy)
    );

    always #50 clkA = ~clkA;

    always begin
        #43 clkB = 1'b1;
        #42 clkB = 1'b0;
    end

    // Destination-side 3-stage synchronizer model.
    always @(posedge clkB) begin
        s1 <= wordA;
        s2 <= s1;
        s3 <= s2;
    end

    task automatic step();
        @(posedge clkA);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb();
        int c;
        c = 0;
        while (wordA_stb !== 1'b1 && c < 40) begin
            step();
            c++;
        end
        chk("stb_seen", {31'd0, wordA_stb}, 32'd1);
    endtask

    task automatic xfer(input int exp_id, input logic [7:0] exp_word, input bit scramble,
                        input int drop_at, input bit chk_cdc, input bit keep);
        int cyc;
        bit stable;
        wait_stb();
        chk("grant_word", {24'd0, wordA}, {24'd0, exp_word});
        chk("grant_id", {30'd0, wordA_id}, exp_id);
        chk("grant_busy", {31'd0, busy}, 32'd1);
        cyc    = 0;
        stable = 1'b1;
        while (req_ack == 4'd0 && cyc < 30) begin
            if (scramble) req_word = $urandom();
            if (cyc == drop_at) req_valid[exp_id] = 1'b0;
            step();
            cyc++;
            if (wordA !== exp_word || wordA_id !== 2'(exp_id) ||
                wordA_stb !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        chk("ack_latency", cyc, 32'd9);
        chk("ack_owner", {28'd0, req_ack}, 32'd1 << exp_id);
        chk("hold_stable", {31'd0, stable}, 32'd1);
        if (chk_cdc) chk("cdc_word", {24'd0, s3}, {24'd0, exp_word});
        req_word = tbl;
        if (!keep) req_valid[exp_id] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit quiet;
        rstA_n    = 1'b0;
        req_valid = 4'd0;
        tbl       = 32'h0000_0007;
        req_word  = tbl;
        step();
        step();
        chk("rst_wordA", {24'd0, wordA}, 32'd0);
        chk("rst_id", {30'd0, wordA_id}, 32'd0);
        chk("rst_stb", {31'd0, wordA_stb}, 32'd0);
        chk("rst_ack", {28'd0, req_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rstA_n = 1'b1;
        step();

        // Single request: 1 grant edge, ack 9 cycles after stb, busy for 10 cycles.
        req_valid = 4'b0001;
        step();
        chk("single_word_at_grant", {24'd0, wordA}, 32'h07);
        chk("single_stb_at_grant", {31'd0, wordA_stb}, 32'd1);
        xfer(0, 8'h07, 1'b0, -1, 1'b0, 1'b0);
        step();
        chk("single_busy_drop", {31'd0, busy}, 32'd0);
        chk("single_ack_drop", {28'd0, req_ack}, 32'd0);
        step();
        chk("single_word_held", {24'd0, wordA}, 32'h07);

        // Round-robin across four simultaneous requesters from rr_ptr=0.
        rstA_n = 1'b0;
        step();
        rstA_n    = 1'b1;
        tbl       = 32'h4433_2211;
        req_word  = tbl;
        req_valid = 4'b1111;
        xfer(0, 8'h11, 1'b0, -1, 1'b0, 1'b0);
        xfer(1, 8'h22, 1'b0, -1, 1'b0, 1'b0);
        xfer(2, 8'h33, 1'b0, -1, 1'b0, 1'b0);
        xfer(3, 8'h44, 1'b0, -1, 1'b0, 1'b0);
        step();
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);

        // Stability with scrambled req_word during hold; CDC model must deliver the word.
        req_valid = 4'b0001;
        xfer(0, 8'h11, 1'b1, -1, 1'b1, 1'b0);
        req_valid = 4'b0100;
        xfer(2, 8'h33, 1'b1, -1, 1'b1, 1'b0);

        // Valid drop two cycles after grant; transfer still acks, next grant avoids 2.
        req_valid = 4'b0100;
        xfer(2, 8'h33, 1'b0, 2, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        xfer(1, 8'h22, 1'b0, -1, 1'b0, 1'b0);

        // Reset during hold at counter value 4.
        req_valid = 4'b0001;
        wait_stb();
        chk("mid_grant_id", {30'd0, wordA_id}, 32'd0);
        step();
        step();
        step();
        step();
        rstA_n = 1'b0;
        step();
        rstA_n    = 1'b1;
        req_valid = 4'd0;
        chk("mid_rst_wordA", {24'd0, wordA}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ack", {28'd0, req_ack}, 32'd0);
        chk("mid_rst_stb", {31'd0, wordA_stb}, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (req_ack !== 4'd0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("mid_rst_no_ack", {31'd0, quiet}, 32'd1);
        tbl       = 32'h4433_5A11;
        req_word  = tbl;
        req_valid = 4'b0010;
        xfer(1, 8'h5A, 1'b0, -1, 1'b0, 1'b0);

        // Requesters 0 and 3 continuously valid.
        rstA_n = 1'b0;
        step();
        rstA_n    = 1'b1;
        tbl       = 32'hA333_22A0;
        req_word  = tbl;
        req_valid = 4'b1001;
`ifdef CDC_SCHED_FIXED_PRIO_EN
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
`else
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
        xfer(3, 8'hA3, 1'b0, -1, 1'b0, 1'b1);
        xfer(0, 8'hA0, 1'b0, -1, 1'b0, 1'b1);
        xfer(3, 8'hA3, 1'b0, -1, 1'b0, 1'b1);
`endif
        req_valid = 4'd0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
